// File: rtl/subservient_dbg_uart_if.sv
// Debug Wishbone master bundle between the UART bridge and the SoC debug port.
// Pure wiring: no state, no latency.
// Backpressure is the slave's ack; the master holds stb until it sees ack.
interface subservient_dbg_uart_if;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_stb;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    modport master (
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb,
        input  i_wb_rdt, i_wb_ack
    );

    modport slave (
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb,
        output i_wb_rdt, i_wb_ack
    );
endinterface

// File: rtl/subservient_dbg_uart.sv
// UART (8N1) to debug-Wishbone bridge: host loads/reads SRAM and halts/releases the core.
// Latency: stb one cycle after the last field byte; TX starts one cycle after ack.
// Backpressure: WB waits for ack indefinitely; RX bytes arriving during WB/RESP are dropped.
// Optional: define SUBSERVIENT_DBG_ACK_EN to answer 'W'/'H'/'G' with a 0x06 byte.
module subservient_dbg_uart #(
    parameter int CLK_DIV = 104
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx,
    output logic                          o_tx,
    output logic                          o_debug_mode,
    subservient_dbg_uart_if.master        wb
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2 - 1);

`ifdef SUBSERVIENT_DBG_ACK_EN
    localparam logic [2:0]    ACK_REM  = 3'd1;
`else
    localparam logic [2:0]    ACK_REM  = 3'd0;
`endif

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_WB, P_RESP} p_state_e;

    // receiver state
    logic            rx_meta_q,  rx_meta_d;
    logic            rx_sync_q,  rx_sync_d;
    logic            rx_last_q,  rx_last_d;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q,   rx_cnt_d;
    logic [2:0]      rx_bit_q,   rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_vld_q,   rx_vld_d;
    logic            rx_ferr_q,  rx_ferr_d;

    // parser / wishbone state
    p_state_e        p_state_q,  p_state_d;
    logic [7:0]      cmd_q,      cmd_d;
    logic [1:0]      fld_cnt_q,  fld_cnt_d;
    logic [31:0]     adr_q,      adr_d;
    logic [31:0]     dat_q,      dat_d;
    logic            stb_q,      stb_d;
    logic            we_q,       we_d;
    logic            dbg_q,      dbg_d;
    logic [31:0]     buf_q,      buf_d;
    logic [2:0]      rem_q,      rem_d;

    // transmitter state
    logic            tx_q,       tx_d;
    logic            tx_busy_q,  tx_busy_d;
    logic [CW-1:0]   tx_cnt_q,   tx_cnt_d;
    logic [3:0]      tx_bit_q,   tx_bit_d;
    logic [8:0]      tx_shift_q, tx_shift_d;

    logic            tx_ready;
    logic            tx_go;

    // Receiver: synchronise, find the start edge, sample each bit at its centre.
    always_comb begin
        rx_meta_d  = i_rx;
        rx_sync_d  = rx_meta_q;
        rx_last_d  = rx_sync_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_vld_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                // edge, not level, so a held-low line after a framing error does not retrigger
                if (rx_last_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == DIV_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_vld_d   = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Parser and transmitter share one block because the parser hands bytes to TX combinationally.
    always_comb begin
        p_state_d  = p_state_q;
        cmd_d      = cmd_q;
        fld_cnt_d  = fld_cnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        stb_d      = stb_q;
        we_d       = we_q;
        dbg_d      = dbg_q;
        buf_d      = buf_q;
        rem_d      = rem_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;

        // TX can take a new byte when idle or in the final clock of a stop bit (back-to-back frames)
        tx_ready = !tx_busy_q || (tx_bit_q == 4'd9 && tx_cnt_q == DIV_LAST);
        tx_go    = (p_state_q == P_RESP) && (rem_q != 3'd0) && tx_ready;

        case (p_state_q)
            P_CMD: begin
                if (rx_vld_q) begin
                    case (rx_shift_q)
                        CMD_W, CMD_R: begin
                            cmd_d     = rx_shift_q;
                            fld_cnt_d = 2'd0;
                            p_state_d = P_ADDR;
                        end
                        CMD_H, CMD_G: begin
                            cmd_d     = rx_shift_q;
                            dbg_d     = (rx_shift_q == CMD_H);
                            buf_d     = 32'h0000_0006;
                            rem_d     = ACK_REM;
                            p_state_d = P_RESP;
                        end
                        default: ;
                    endcase
                end
            end
            P_ADDR: begin
                if (rx_ferr_q) begin
                    p_state_d = P_CMD;
                end else if (rx_vld_q) begin
                    adr_d     = {rx_shift_q, adr_q[31:8]};
                    fld_cnt_d = fld_cnt_q + 2'd1;
                    if (fld_cnt_q == 2'd3) begin
                        if (cmd_q == CMD_W) begin
                            p_state_d = P_DATA;
                        end else begin
                            stb_d     = 1'b1;
                            we_d      = 1'b0;
                            p_state_d = P_WB;
                        end
                    end
                end
            end
            P_DATA: begin
                if (rx_ferr_q) begin
                    p_state_d = P_CMD;
                end else if (rx_vld_q) begin
                    dat_d     = {rx_shift_q, dat_q[31:8]};
                    fld_cnt_d = fld_cnt_q + 2'd1;
                    if (fld_cnt_q == 2'd3) begin
                        stb_d     = 1'b1;
                        we_d      = 1'b1;
                        p_state_d = P_WB;
                    end
                end
            end
            P_WB: begin
                // RX bytes and framing errors are ignored here so an open bus cycle is never abandoned
                if (wb.i_wb_ack) begin
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    p_state_d = P_RESP;
                    if (cmd_q == CMD_R) begin
                        buf_d = wb.i_wb_rdt;
                        rem_d = 3'd4;
                    end else begin
                        buf_d = 32'h0000_0006;
                        rem_d = ACK_REM;
                    end
                end
            end
            P_RESP: begin
                if (tx_go) begin
                    buf_d = {8'h00, buf_q[31:8]};
                    rem_d = rem_q - 3'd1;
                end else if (rem_q == 3'd0 && !tx_busy_q) begin
                    p_state_d = P_CMD;
                end
            end
            default: p_state_d = P_CMD;
        endcase

        // TX frame: bit 0 is the start bit, 1..8 data, 9 the stop bit
        if (tx_go) begin
            tx_d       = 1'b0;
            tx_shift_d = {1'b1, buf_q[7:0]};
            tx_bit_d   = 4'd0;
            tx_cnt_d   = '0;
            tx_busy_d  = 1'b1;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == DIV_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_d      = 1'b1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset puts the core in debug mode with the bus idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_last_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_vld_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            p_state_q  <= P_CMD;
            cmd_q      <= 8'h00;
            fld_cnt_q  <= 2'd0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            dbg_q      <= 1'b1;
            buf_q      <= 32'h0;
            rem_q      <= 3'd0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= 9'h1FF;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_last_q  <= rx_last_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_vld_q   <= rx_vld_d;
            rx_ferr_q  <= rx_ferr_d;
            p_state_q  <= p_state_d;
            cmd_q      <= cmd_d;
            fld_cnt_q  <= fld_cnt_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            dbg_q      <= dbg_d;
            buf_q      <= buf_d;
            rem_q      <= rem_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    assign o_tx         = tx_q;
    assign o_debug_mode = dbg_q;
    assign wb.o_wb_adr  = adr_q;
    assign wb.o_wb_dat  = dat_q;
    assign wb.o_wb_sel  = 4'hF;
    assign wb.o_wb_we   = we_q;
    assign wb.o_wb_stb  = stb_q;

endmodule

// File: tb/tb_subservient_dbg_uart.sv
// Directed bench for the UART debug bridge: drives host frames, models a WB slave and a UART receiver.
// Latency checked via stb hold length and TX frame spacing.
// Backpressure exercised with a delayed ack and an ack that never comes (reset mid-cycle).
module tb_subservient_dbg_uart;

    localparam int DIV = 16;

    logic clk;
    logic rst_n;
    logic rx;
    logic tx;
    logic dbg;

    subservient_dbg_uart_if wb_if ();

    subservient_dbg_uart #(.CLK_DIV(DIV)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx         (rx),
        .o_tx         (tx),
        .o_debug_mode (dbg),
        .wb           (wb_if.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // WB slave model state
    int          ack_dly  = 0;
    logic [31:0] rd_val   = 32'h0;
    int          nwb      = 0;
    int          stb_cnt  = 0;
    int          last_stb = 0;
    logic [31:0] last_adr;
    logic [31:0] last_dat;
    logic [3:0]  last_sel;
    logic        last_we;

    // captured TX bytes and the cycle each start bit was seen
    logic [7:0] txq[$];
    int         txt[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // WB slave: acks after ack_dly extra stb cycles, read data only valid during ack
    initial begin
        int dly;
        dly = 0;
        wb_if.i_wb_ack = 1'b0;
        wb_if.i_wb_rdt = 32'h0;
        forever begin
            @(negedge clk);
            if (wb_if.o_wb_stb) stb_cnt++; else stb_cnt = 0;
            if (wb_if.i_wb_ack) begin
                wb_if.i_wb_ack = 1'b0;
                wb_if.i_wb_rdt = 32'h0;
            end else if (wb_if.o_wb_stb) begin
                if (dly == ack_dly) begin
                    wb_if.i_wb_ack = 1'b1;
                    wb_if.i_wb_rdt = rd_val;
                    last_adr = wb_if.o_wb_adr;
                    last_dat = wb_if.o_wb_dat;
                    last_sel = wb_if.o_wb_sel;
                    last_we  = wb_if.o_wb_we;
                    last_stb = stb_cnt;
                    nwb++;
                    dly = 0;
                end else begin
                    dly++;
                end
            end else begin
                dly = 0;
            end
        end
    end

    // UART receiver model sampling o_tx at bit centres
    initial forever begin
        logic [7:0] b;
        int         t0;
        @(negedge clk);
        if (tx === 1'b0) begin
            t0 = cyc;
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                b[i] = tx;
            end
            repeat (DIV) @(negedge clk);
            check("tx_stop_bit", {31'h0, tx}, 32'h1);
            txq.push_back(b);
            txt.push_back(t0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_wb(input string tag, input int n);
        int k;
        k = 0;
        while (nwb < n && k < 20 * DIV) begin
            @(negedge clk);
            k++;
        end
        check(tag, nwb, n);
    endtask

    task automatic wait_tx(input string tag, input int n);
        int k;
        k = 0;
        while (txq.size() < n && k < 60 * DIV) begin
            @(negedge clk);
            k++;
        end
        check(tag, txq.size(), n);
    endtask

    task automatic clear_tx();
        txq.delete();
        txt.delete();
    endtask

    // after 'W'/'H'/'G': one 0x06 byte with the ack option, otherwise a silent line
    task automatic expect_ack(input string tag);
        repeat (14 * DIV) @(negedge clk);
`ifdef SUBSERVIENT_DBG_ACK_EN
        check({tag, "_ack_cnt"}, txq.size(), 1);
        if (txq.size() > 0) check({tag, "_ack_byte"}, {24'h0, txq[0]}, 32'h06);
`else
        check({tag, "_tx_silent"}, txq.size(), 0);
`endif
        clear_tx();
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx",  {31'h0, tx}, 32'h1);
        check("rst_dbg", {31'h0, dbg}, 32'h1);
        check("rst_stb", {31'h0, wb_if.o_wb_stb}, 32'h0);
        check("rst_we",  {31'h0, wb_if.o_wb_we}, 32'h0);
        check("rst_adr", wb_if.o_wb_adr, 32'h0);
        check("rst_dat", wb_if.o_wb_dat, 32'h0);
        check("rst_sel", {28'h0, wb_if.o_wb_sel}, 32'hF);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // write 0xDEADBEEF to 0x100 with a 3-cycle ack delay
        ack_dly = 3;
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_wb("wr_done", 1);
        check("wr_adr", last_adr, 32'h0000_0100);
        check("wr_dat", last_dat, 32'hDEAD_BEEF);
        check("wr_sel", {28'h0, last_sel}, 32'hF);
        check("wr_we",  {31'h0, last_we}, 32'h1);
        check("wr_stb_len", last_stb, 4);
        @(negedge clk);
        check("wr_stb_drop", {31'h0, wb_if.o_wb_stb}, 32'h0);
        expect_ack("wr");

        // read 0x100, slave returns 0x12345678
        ack_dly = 0;
        rd_val  = 32'h1234_5678;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        wait_wb("rd_done", 2);
        check("rd_adr", last_adr, 32'h0000_0100);
        check("rd_we",  {31'h0, last_we}, 32'h0);
        wait_tx("rd_tx_cnt", 4);
        if (txq.size() == 4) begin
            check("rd_b0", {24'h0, txq[0]}, 32'h78);
            check("rd_b1", {24'h0, txq[1]}, 32'h56);
            check("rd_b2", {24'h0, txq[2]}, 32'h34);
            check("rd_b3", {24'h0, txq[3]}, 32'h12);
            for (int i = 1; i < 4; i++) check("rd_spacing", txt[i] - txt[i-1], 10 * DIV);
        end
        clear_tx();
        repeat (2 * DIV) @(negedge clk);

        // go / halt and junk bytes
        send_byte(8'h47);
        check("go_dbg", {31'h0, dbg}, 32'h0);
        expect_ack("go");
        send_byte(8'h48);
        check("halt_dbg", {31'h0, dbg}, 32'h1);
        expect_ack("halt");
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (4 * DIV) @(negedge clk);
        check("junk_nwb", nwb, 2);
        check("junk_stb", {31'h0, wb_if.o_wb_stb}, 32'h0);
        check("junk_tx",  txq.size(), 0);

        // short low glitch inside a read command must not become a byte
        send_byte(8'h52);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        wait_wb("gl_done", 3);
        check("gl_adr", last_adr, 32'h0000_0200);
        wait_tx("gl_tx_cnt", 4);
        clear_tx();
        repeat (2 * DIV) @(negedge clk);

        // framing error inside a write, then a clean read
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h01, 1'b0);
        send_byte(8'h52);
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_wb("fe_done", 4);
        check("fe_adr", last_adr, 32'h0000_0004);
        check("fe_we",  {31'h0, last_we}, 32'h0);
        wait_tx("fe_tx_cnt", 4);
        clear_tx();
        repeat (2 * DIV) @(negedge clk);

        // async reset while stb is waiting on an ack that never comes
        send_byte(8'h47);
        check("rs_go_dbg", {31'h0, dbg}, 32'h0);
        expect_ack("rs_go");
        ack_dly = 1000000;
        send_byte(8'h57);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        begin
            int k;
            k = 0;
            while (!wb_if.o_wb_stb && k < 4 * DIV) begin
                @(negedge clk);
                k++;
            end
        end
        check("rs_stb_seen", {31'h0, wb_if.o_wb_stb}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rs_stb", {31'h0, wb_if.o_wb_stb}, 32'h0);
        check("rs_dbg", {31'h0, dbg}, 32'h1);
        check("rs_we",  {31'h0, wb_if.o_wb_we}, 32'h0);
        check("rs_adr", wb_if.o_wb_adr, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
